// File: rtl/int_xing_sink.sv
`default_nettype none
// ============================================================================
// Module   : int_xing_sink
// Purpose  : Synchronizes foreign-domain interrupt lines into the core clock,
//            captures them as level/edge pending bits and serves them through a
//            claim/complete handshake. Optional glitch filter: IRQ_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module int_xing_sink #(
  parameter  int NUM_IRQ       = 2,
  parameter  int SYNC_STAGES   = 3,
  parameter  int FILTER_CYCLES = 4,
  localparam int ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] edge_mode,
  output logic [NUM_IRQ-1:0] pending,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               claim_ready,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  output logic [NUM_IRQ-1:0] in_service
);

  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IRQ-1:0] w_sync;
  logic [NUM_IRQ-1:0] w_filt;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_in_service;
  logic [NUM_IRQ-1:0] w_avail;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_claim_dec;
  logic [NUM_IRQ-1:0] w_cmpl_dec;
  logic [ID_W-1:0]    w_claim_id;
  logic               w_accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef IRQ_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_filter
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // Counter tracks consecutive cycles the synced input disagrees with the
    // filtered level; any agreement restarts the count.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (w_sync[i] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= w_sync[i];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_filt[i] = r_level;
  end
`else
  logic w_unused_filter;
  assign w_unused_filter = (FILTER_CYCLES > 0);
  assign w_filt          = w_sync;
`endif

  assign w_rise   = w_filt & ~r_prev;
  assign w_avail  = r_pending & ~r_in_service;
  assign w_accept = (|w_avail) & claim_ready;

  always_comb begin
    w_claim_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_avail[i]) w_claim_id = ID_W'(i);
    end
  end

  // Decoding only indices below NUM_IRQ drops out-of-range completes for free.
  always_comb begin
    w_claim_dec = '0;
    w_cmpl_dec  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_claim_dec[i] = w_accept && (w_claim_id == ID_W'(i));
      w_cmpl_dec[i]  = complete_valid && (complete_id == ID_W'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev       <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
    end else begin
      r_prev       <= w_filt;
      r_pending    <= (edge_mode & (w_rise | (r_pending & ~w_claim_dec)))
                    | (~edge_mode & w_filt);
      r_in_service <= (r_in_service & ~w_cmpl_dec) | w_claim_dec;
    end
  end

  assign pending     = r_pending;
  assign in_service  = r_in_service;
  assign claim_valid = |w_avail;
  assign claim_id    = w_claim_id;

endmodule
`default_nettype wire

// File: tb/tb_int_xing_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_xing_sink
// Purpose  : Self-checking bench for int_xing_sink: directed vector tables and
//            randomized traffic against a history-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_xing_sink;

  localparam int NUM_IRQ       = 2;
  localparam int SYNC_STAGES   = 3;
  localparam int FILTER_CYCLES = 4;
  localparam int ID_W          = 1;
  localparam int HL            = SYNC_STAGES + FILTER_CYCLES + 2;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_IRQ-1:0] irq_in = '0;
  logic [NUM_IRQ-1:0] edge_mode = '0;
  logic               claim_ready = 1'b0;
  logic               complete_valid = 1'b0;
  logic [ID_W-1:0]    complete_id = '0;
  logic [NUM_IRQ-1:0] pending;
  logic               claim_valid;
  logic [ID_W-1:0]    claim_id;
  logic [NUM_IRQ-1:0] in_service;

  int n_checks = 0;
  int n_pass   = 0;

  int_xing_sink #(
    .NUM_IRQ      (NUM_IRQ),
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .irq_in        (irq_in),
    .edge_mode     (edge_mode),
    .pending       (pending),
    .claim_valid   (claim_valid),
    .claim_id      (claim_id),
    .claim_ready   (claim_ready),
    .complete_valid(complete_valid),
    .complete_id   (complete_id),
    .in_service    (in_service)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] em;
    logic               cr;
    logic               cv;
    logic [ID_W-1:0]    cid;
    logic [NUM_IRQ-1:0] e_pend;
    logic [NUM_IRQ-1:0] e_isv;
    logic               e_cv;
    logic [ID_W-1:0]    e_cid;
  } vec_t;

  vec_t vecs[$];

  // Reference model: raw input history stands in for the synchronizer.
  logic [NUM_IRQ-1:0] hist[$];
  logic [NUM_IRQ-1:0] m_pend, m_isv, m_f, m_prev;

  function automatic void add(input logic [NUM_IRQ-1:0] irq, input logic [NUM_IRQ-1:0] em,
                              input logic cr, input logic cv, input logic [ID_W-1:0] cid,
                              input logic [NUM_IRQ-1:0] ep, input logic [NUM_IRQ-1:0] ei,
                              input logic ecv, input logic [ID_W-1:0] ecid);
    vec_t v;
    v.irq = irq; v.em = em; v.cr = cr; v.cv = cv; v.cid = cid;
    v.e_pend = ep; v.e_isv = ei; v.e_cv = ecv; v.e_cid = ecid;
    vecs.push_back(v);
  endfunction

  function automatic logic m_cv();
    return |(m_pend & ~m_isv);
  endfunction

  function automatic logic [ID_W-1:0] m_cid();
    for (int i = 0; i < NUM_IRQ; i++)
      if (m_pend[i] && !m_isv[i]) return ID_W'(i);
    return '0;
  endfunction

  function automatic void model_reset();
    m_pend = '0; m_isv = '0; m_f = '0; m_prev = '0;
    hist.delete();
    for (int k = 0; k < HL; k++) hist.push_back('0);
  endfunction

  function automatic void model_step();
    logic [NUM_IRQ-1:0] lvl, rise, nf, np, ni;
    logic               acc;
    logic [ID_W-1:0]    cid;
    hist.push_front(irq_in);
    void'(hist.pop_back());
`ifdef IRQ_FILTER_EN
    nf = m_f;
    for (int i = 0; i < NUM_IRQ; i++) begin
      bit all_differ = 1'b1;
      for (int j = 0; j < FILTER_CYCLES; j++)
        if (hist[SYNC_STAGES + j][i] == m_f[i]) all_differ = 1'b0;
      if (all_differ) nf[i] = ~m_f[i];
    end
    lvl    = m_f;
    rise   = m_f & ~m_prev;
    m_prev = m_f;
    m_f    = nf;
`else
    nf   = '0;
    lvl  = hist[SYNC_STAGES];
    rise = hist[SYNC_STAGES] & ~hist[SYNC_STAGES + 1];
`endif
    acc = m_cv() && claim_ready;
    cid = m_cid();
    np  = m_pend;
    ni  = m_isv;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (edge_mode[i]) np[i] = rise[i] || (m_pend[i] && !(acc && int'(cid) == i));
      else              np[i] = lvl[i];
    end
    if (complete_valid && int'(complete_id) < NUM_IRQ) ni[complete_id] = 1'b0;
    if (acc) ni[cid] = 1'b1;
    m_pend = np;
    m_isv  = ni;
  endfunction

  task automatic check(input string name, input logic [NUM_IRQ-1:0] ep,
                       input logic [NUM_IRQ-1:0] ei, input logic ecv, input logic [ID_W-1:0] ecid);
    n_checks++;
    if (pending === ep && in_service === ei && claim_valid === ecv && claim_id === ecid)
      n_pass++;
    else
      $display("FAIL %s @%0t: got pend=%b isv=%b cv=%b id=%0d, want pend=%b isv=%b cv=%b id=%0d",
               name, $time, pending, in_service, claim_valid, claim_id, ep, ei, ecv, ecid);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("model", m_pend, m_isv, m_cv(), m_cid());
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int n = first; n < last; n++) begin
      irq_in         = vecs[n].irq;
      edge_mode      = vecs[n].em;
      claim_ready    = vecs[n].cr;
      complete_valid = vecs[n].cv;
      complete_id    = vecs[n].cid;
      tick();
      check($sformatf("vec%0d", n), vecs[n].e_pend, vecs[n].e_isv, vecs[n].e_cv, vecs[n].e_cid);
    end
    claim_ready    = 1'b0;
    complete_valid = 1'b0;
  endtask

  task automatic async_reset(input string name);
    reset = 1'b1;
    #1;
    model_reset();
    check(name, '0, '0, 1'b0, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int split;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    repeat (10) tick();
    check("reset_idle", 2'b00, 2'b00, 1'b0, 1'b0);

`ifdef IRQ_FILTER_EN
    edge_mode = 2'b11;
    for (int k = 0; k < 14; k++) begin
      irq_in = (k < 2) ? 2'b10 : 2'b00;
      tick();
      check("short_pulse", 2'b00, 2'b00, 1'b0, 1'b0);
    end
    for (int k = 0; k < 12; k++) begin
      irq_in = (k < 10) ? 2'b01 : 2'b00;
      tick();
      check($sformatf("long_pulse%0d", k), (k >= 7) ? 2'b01 : 2'b00, 2'b00, k >= 7, 1'b0);
    end
    claim_ready = 1'b1;
    tick();
    claim_ready = 1'b0; complete_valid = 1'b1; complete_id = 1'b0;
    tick();
    complete_valid = 1'b0;
`else
    // Edge line 1 rises: pending on 4th edge, claim, complete.
    repeat (3) add(2'b10, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b10, 2'b11, 0, 0, 0, 2'b10, 2'b00, 1, 1);
    add(2'b10, 2'b11, 1, 0, 0, 2'b00, 2'b10, 0, 0);
    add(2'b10, 2'b11, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    repeat (4) add(2'b00, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    // Level lines held high; completed line still high is re-presented.
    repeat (3) add(2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b11, 2'b00, 0, 0, 0, 2'b11, 2'b00, 1, 0);
    add(2'b11, 2'b00, 1, 0, 0, 2'b11, 2'b01, 1, 1);
    add(2'b11, 2'b00, 0, 1, 0, 2'b11, 2'b00, 1, 0);
    add(2'b11, 2'b00, 1, 0, 0, 2'b11, 2'b01, 1, 1);
    add(2'b11, 2'b00, 1, 0, 0, 2'b11, 2'b11, 0, 0);
    repeat (3) add(2'b00, 2'b00, 0, 0, 0, 2'b11, 2'b11, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b11, 0, 0);
    add(2'b00, 2'b00, 0, 1, 1, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b00, 0, 1, 1, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 0);
    // Edge line 0: second rise lands on the same edge as its claim accept.
    add(2'b01, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b01, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b01, 2'b01, 0, 0, 0, 2'b01, 2'b00, 1, 0);
    add(2'b01, 2'b01, 0, 0, 0, 2'b01, 2'b00, 1, 0);
    add(2'b01, 2'b01, 1, 0, 0, 2'b01, 2'b01, 0, 0);
    add(2'b01, 2'b01, 0, 1, 0, 2'b01, 2'b00, 1, 0);
    add(2'b01, 2'b01, 1, 0, 0, 2'b00, 2'b01, 0, 0);
    split = vecs.size();
    // After reset with line 0 still high, its edge appears 4 edges later.
    repeat (3) add(2'b01, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b01, 2'b01, 0, 0, 0, 2'b01, 2'b00, 1, 0);
    add(2'b01, 2'b01, 1, 0, 0, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b01, 0, 1, 0, 2'b00, 2'b00, 0, 0);

    run_vecs(0, split);
    async_reset("reset_mid_service");
    run_vecs(split, vecs.size());
`endif

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_IRQ; i++)
        if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
      if ($urandom_range(0, 63) == 0) edge_mode = NUM_IRQ'($urandom_range(0, 3));
      claim_ready    = 1'($urandom_range(0, 1));
      complete_valid = ($urandom_range(0, 3) == 0);
      complete_id    = ID_W'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) async_reset("random_reset");
      else tick();
    end

    claim_ready    = 1'b0;
    complete_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
